ram_sync_hs: RTL and testbench
==============================

// Module: ram_sync_hs
// PURPOSE
// Parametrised single-port synchronous RAM with a valid/ready request handshake, per-byte write
// enables, a configurable read pipeline and a post-reset hardware clear sweep.
// Generalised successor to the fixed 2048x32 negedge RAM; sits between the CPU/bus fabric and
// local data memory, so no block ever sees stale contents after reset.
// PARAMETERS
// DATA_WIDTH    32  word width in bits; must be a multiple of 8
// ADDR_WIDTH    11  address bits; depth = 2**ADDR_WIDTH words
// READ_LATENCY  1   cycles from accepted read to rsp_valid; legal range 1..4
// PORTS
// clock        in   1             rising-edge clock for all state
// reset        in   1             asynchronous, active-high; clears all state and restarts clear sweep
// chip_select  in   1             block enable; request accepted only when high
// req_valid    in   1             request present this cycle
// req_ready    out  1             block can accept a request this cycle
// we           in   1             1 = write, 0 = read (sampled with request)
// address      in   ADDR_WIDTH    word address
// byte_en      in   DATA_WIDTH/8  per-byte write enable; ignored on reads
// data_in      in   DATA_WIDTH    write data
// rsp_valid    out  1             data_out holds read data this cycle (1-cycle pulse per read)
// data_out     out  DATA_WIDTH    read data; holds last value when rsp_valid low
// init_done    out  1             high once clear sweep complete
// BEHAVIOUR
// - Reset (async assert, sync release): req_ready=0, rsp_valid=0, data_out=0, init_done=0,
//   read pipeline flushed, FSM -> CLEAR, sweep pointer=0.
// - FSM CLEAR: writes 0 to word[ptr] each cycle, ptr+1; after writing word 2**ADDR_WIDTH-1
//   -> RUN, init_done=1 the next cycle. Sweep takes exactly 2**ADDR_WIDTH cycles.
// - FSM RUN: req_ready = 1 combinationally (no stalls); stays in RUN until reset.
// - Accept = req_valid & req_ready & chip_select; requests without chip_select are dropped,
//   produce no response and no write.
// - Write: on accept edge, byte i of word[address] <= data_in byte i where byte_en[i]=1;
//   other bytes unchanged. byte_en=0 is a legal no-op write. No response generated.
// - Read: word sampled on accept edge; rsp_valid pulses exactly READ_LATENCY cycles later with
//   data_out; one read per cycle, fully pipelined, responses in order, no backpressure.
// - Read of an address written on the same edge returns OLD data; write visible to reads
//   accepted on later edges, including reads already issued earlier being unaffected.
// - Reset mid-operation: in-flight reads discarded (no rsp_valid), pending write on that edge
//   not guaranteed; memory re-cleared by sweep.
// - Address is always in range (power-of-two depth); no wrap logic beyond natural truncation.
// - Illegal READ_LATENCY (outside 1..4) or DATA_WIDTH%8!=0: elaboration error via generate check.
// CONFIGURATION
// RAM_SYNC_PARITY_EN defined: one even-parity bit stored per byte, written with data (and as 0
//   with zero data during sweep); checked on read; adds output parity_err (1 bit) pulsing
//   with rsp_valid when any byte of the read word mismatches; reset value 0.
// RAM_SYNC_PARITY_EN undefined: no parity storage, no parity_err port; otherwise identical.
// TESTING
// 1 Reset, ADDR_WIDTH=4: req_ready=0 for 16 cycles, init_done=1 at cycle 17; read all 16 -> 0.
// 2 Write 0xDEADBEEF @5 byte_en=4'b1111, then byte_en=4'b0010 data 0x00001200 @5; read @5
//   -> 0xDEAD12EF, rsp_valid exactly READ_LATENCY cycles after accept (run LAT=1 and 3).
// 3 Back-to-back reads @1,@2,@3 on consecutive cycles with LAT=2 -> three consecutive rsp_valid
//   pulses, data in order.
// 4 Same-edge write 0x11 @7 and (next cycle) read @7 vs read issued on write edge -> old 0x0
//   for same-edge read, 0x11 for later read; chip_select=0 write @7 -> word unchanged.
// 5 Assert reset with 2 reads in flight (LAT=3) -> no rsp_valid, data_out=0, sweep restarts.
// 6 RAM_SYNC_PARITY_EN: force-flip one stored bit @9 via hierarchical deposit, read @9
//   -> parity_err=1 with rsp_valid; clean read @8 -> parity_err=0.

Source files
------------

// File: rtl/ram_sync_hs_if.sv
// Request/response bundle for ram_sync_hs.
// The master side (CPU/bus fabric) drives requests. The slave side (the RAM)
// returns readiness, read data and init status.
// With RAM_SYNC_PARITY_EN defined, the bundle also carries parity_err.
interface ram_sync_hs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    logic                    chip_select;
    logic                    req_valid;
    logic                    req_ready;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    init_done;
`ifdef RAM_SYNC_PARITY_EN
    logic                    parity_err;
`endif

    modport master (
        output chip_select, req_valid, we, address, byte_en, data_in,
        input  req_ready, rsp_valid, data_out, init_done
`ifdef RAM_SYNC_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  chip_select, req_valid, we, address, byte_en, data_in,
        output req_ready, rsp_valid, data_out, init_done
`ifdef RAM_SYNC_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/ram_sync_hs.sv
// ram_sync_hs: single-port synchronous RAM with a valid/ready request port.
// It supports per-byte write enables and a 1..4 cycle read pipeline.
// After every reset, a hardware sweep writes zero to the whole array.
// Optional feature macro: RAM_SYNC_PARITY_EN. When it is defined, the RAM
// stores one even-parity bit per byte and adds a parity_err output.
module ram_sync_hs #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic         clock,
    input  logic         reset,
    ram_sync_hs_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
`ifdef RAM_SYNC_PARITY_EN
    localparam int LANE_W = 9;
    localparam int PIPE_W = DATA_WIDTH + 1;
`else
    localparam int LANE_W = 8;
    localparam int PIPE_W = DATA_WIDTH;
`endif

    // Reject configurations the datapath cannot represent.
    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("ram_sync_hs: READ_LATENCY must be within 1..4");
        end
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("ram_sync_hs: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
    logic                    sweep_w;
    logic                    ready_w;
    logic                    accept_w;
    logic                    wr_accept_w;
    logic                    rd_accept_w;
    logic [ADDR_WIDTH-1:0]   mem_addr_w;
    logic [DATA_WIDTH-1:0]   rd_word_w;
    logic [PIPE_W-1:0]       stage1_word_w;
    logic [PIPE_W-1:0]       final_word_w;
    logic [READ_LATENCY:1]   valid_pipe_reg;
    logic                    live_reg;
    logic                    rsp_valid_w;
`ifdef RAM_SYNC_PARITY_EN
    logic [NUM_BYTES-1:0]    lane_perr_w;
`endif

    // State register: reset always restarts the clear sweep from word 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next state: sweep one word per cycle, then serve requests until the next reset.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sweep_w    = 1'b0;
        ready_w    = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                sweep_w  = 1'b1;
                ptr_next = ptr_reg + ADDR_WIDTH'(1);
                if (&ptr_reg) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                ready_w = 1'b1;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    assign accept_w    = bus.req_valid & ready_w & bus.chip_select;
    assign wr_accept_w = accept_w & bus.we;
    assign rd_accept_w = accept_w & ~bus.we;
    // During the sweep the single port belongs to the clear pointer.
    assign mem_addr_w  = sweep_w ? ptr_reg : bus.address;

    // One RAM per byte lane keeps per-byte enables a plain write enable.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_mem [DEPTH];
            logic [LANE_W-1:0] lane_rd_reg;
            logic [LANE_W-1:0] lane_wdata_w;
            logic [7:0]        wr_byte_w;
            logic              lane_we_w;

            assign wr_byte_w = sweep_w ? 8'h00 : bus.data_in[gi*8 +: 8];
            assign lane_we_w = sweep_w | (wr_accept_w & bus.byte_en[gi]);
`ifdef RAM_SYNC_PARITY_EN
            assign lane_wdata_w    = {^wr_byte_w, wr_byte_w};
            assign lane_perr_w[gi] = ^lane_rd_reg;
`else
            assign lane_wdata_w = wr_byte_w;
`endif

            // Lane storage. The registered read returns the pre-write contents on a shared edge.
            always_ff @(posedge clock) begin
                if (lane_we_w) begin
                    lane_mem[mem_addr_w] <= lane_wdata_w;
                end
                if (rd_accept_w) begin
                    lane_rd_reg <= lane_mem[mem_addr_w];
                end
            end

            assign rd_word_w[gi*8 +: 8] = lane_rd_reg[7:0];
        end
    endgenerate

`ifdef RAM_SYNC_PARITY_EN
    assign stage1_word_w = {|lane_perr_w, rd_word_w};
`else
    assign stage1_word_w = rd_word_w;
`endif

    // Valid shift register: one bit per cycle of read latency; reset drops in-flight reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_pipe_reg <= '0;
        end else begin
            valid_pipe_reg[1] <= rd_accept_w;
            for (int k = 2; k <= READ_LATENCY; k++) begin
                valid_pipe_reg[k] <= valid_pipe_reg[k-1];
            end
        end
    end

    // Data stages after the RAM read register. Each stage loads only with its valid bit so the output holds.
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign final_word_w = stage1_word_w;
        end else begin : g_latn
            logic [PIPE_W-1:0] pipe_reg [READ_LATENCY-1];

            // Shift a read word one stage further each time its valid bit advances.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < READ_LATENCY - 1; k++) begin
                        pipe_reg[k] <= '0;
                    end
                end else begin
                    if (valid_pipe_reg[1]) begin
                        pipe_reg[0] <= stage1_word_w;
                    end
                    for (int k = 1; k < READ_LATENCY - 1; k++) begin
                        if (valid_pipe_reg[k+1]) begin
                            pipe_reg[k] <= pipe_reg[k-1];
                        end
                    end
                end
            end

            assign final_word_w = pipe_reg[READ_LATENCY-2];
        end
    endgenerate

    assign rsp_valid_w = valid_pipe_reg[READ_LATENCY];

    // data_out stays zero after reset until the first response. The lane read registers are not reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live_reg <= 1'b0;
        end else if (rsp_valid_w) begin
            live_reg <= 1'b1;
        end
    end

    assign bus.req_ready = ready_w;
    assign bus.init_done = (state_reg == ST_RUN);
    assign bus.rsp_valid = rsp_valid_w;
    assign bus.data_out  = (rsp_valid_w | live_reg) ? final_word_w[DATA_WIDTH-1:0] : '0;
`ifdef RAM_SYNC_PARITY_EN
    assign bus.parity_err = rsp_valid_w & final_word_w[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_ram_sync_hs.sv
// Testbench for ram_sync_hs.
// Three DUTs share one stimulus stream. They differ only in READ_LATENCY (1, 2, 3).
// Every step checks each DUT's response timing against its own latency.
module tb_ram_sync_hs;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NB   = DW / 8;
    localparam int NDUT = 3;
    localparam int MAXOPS = 32;

    logic          clk;
    logic          rst;
    logic          cs;
    logic          req_v;
    logic          we;
    logic [AW-1:0] addr;
    logic [NB-1:0] be;
    logic [DW-1:0] din;

    logic [NDUT-1:0] ready_o;
    logic [NDUT-1:0] rsp_o;
    logic [NDUT-1:0] init_o;
    logic [DW-1:0]   dout_o [NDUT];
`ifdef RAM_SYNC_PARITY_EN
    logic [NDUT-1:0] perr_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Operation table consumed by run_ops
    int            n_ops = 0;
    logic          op_we   [MAXOPS];
    logic          op_cs   [MAXOPS];
    logic [AW-1:0] op_addr [MAXOPS];
    logic [DW-1:0] op_data [MAXOPS];
    logic [NB-1:0] op_be   [MAXOPS];
    logic [DW-1:0] op_exp  [MAXOPS];
    logic          op_pe   [MAXOPS];

    ram_sync_hs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus [NDUT] ();

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            assign bus[gi].chip_select = cs;
            assign bus[gi].req_valid   = req_v;
            assign bus[gi].we          = we;
            assign bus[gi].address     = addr;
            assign bus[gi].byte_en     = be;
            assign bus[gi].data_in     = din;
            assign ready_o[gi] = bus[gi].req_ready;
            assign rsp_o[gi]   = bus[gi].rsp_valid;
            assign init_o[gi]  = bus[gi].init_done;
            assign dout_o[gi]  = bus[gi].data_out;
`ifdef RAM_SYNC_PARITY_EN
            assign perr_o[gi]  = bus[gi].parity_err;
`endif
            ram_sync_hs #(
                .DATA_WIDTH  (DW),
                .ADDR_WIDTH  (AW),
                .READ_LATENCY(gi + 1)
            ) u_dut (
                .clock(clk),
                .reset(rst),
                .bus  (bus[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cs    = 1'b0;
        req_v = 1'b0;
        we    = 1'b0;
        addr  = '0;
        be    = '0;
        din   = '0;
    endtask

    task automatic add_op(input logic w, input logic c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NB-1:0] b,
                          input logic [DW-1:0] e, input logic p);
        op_we[n_ops]   = w;
        op_cs[n_ops]   = c;
        op_addr[n_ops] = a;
        op_data[n_ops] = d;
        op_be[n_ops]   = b;
        op_exp[n_ops]  = e;
        op_pe[n_ops]   = p;
        n_ops++;
    endtask

    // Issue the op table one request per cycle, then check every DUT's response stream.
    task automatic run_ops();
        int            last;
        logic [DW-1:0] last_exp;
        last     = -1;
        last_exp = '0;
        for (int s = 0; s < n_ops + NDUT; s++) begin
            if (s < n_ops) begin
                cs    = op_cs[s];
                req_v = 1'b1;
                we    = op_we[s];
                addr  = op_addr[s];
                be    = op_be[s];
                din   = op_data[s];
                $display("op %0d: we=%0b cs=%0b addr=%0d data=%h be=%b", s, op_we[s], op_cs[s], op_addr[s], op_data[s], op_be[s]);
                if (op_cs[s] && !op_we[s]) begin
                    last     = s;
                    last_exp = op_exp[s];
                end
            end else begin
                drive_idle();
            end
            tick();
            for (int i = 0; i < NDUT; i++) begin
                int   k;
                logic ev;
                k  = s - i;
                ev = (k >= 0 && k < n_ops) ? (op_cs[k] & ~op_we[k]) : 1'b0;
                check_eq($sformatf("rsp_valid lat%0d step%0d", i + 1, s), DW'(rsp_o[i]), DW'(ev));
                if (ev) begin
                    check_eq($sformatf("data_out lat%0d op%0d", i + 1, k), dout_o[i], op_exp[k]);
`ifdef RAM_SYNC_PARITY_EN
                    check_eq($sformatf("parity_err lat%0d op%0d", i + 1, k), DW'(perr_o[i]), DW'(op_pe[k]));
`endif
                end
            end
        end
        if (last >= 0) begin
            for (int i = 0; i < NDUT; i++) begin
                check_eq($sformatf("data_out hold lat%0d", i + 1), dout_o[i], last_exp);
            end
        end
        n_ops = 0;
    endtask

    // Reset with outputs checked while it is asserted, then release it and time the clear sweep.
    task automatic apply_reset();
        int cycles;
        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                check_eq($sformatf("rst req_ready lat%0d", i + 1), DW'(ready_o[i]), '0);
                check_eq($sformatf("rst rsp_valid lat%0d", i + 1), DW'(rsp_o[i]), '0);
                check_eq($sformatf("rst data_out lat%0d", i + 1), dout_o[i], '0);
                check_eq($sformatf("rst init_done lat%0d", i + 1), DW'(init_o[i]), '0);
            end
            tick();
        end
        rst    = 1'b0;
        cycles = 1;
        while (!ready_o[0] && cycles < 100) begin
            check_eq($sformatf("sweep rsp_valid c%0d", cycles), DW'(rsp_o), '0);
            check_eq($sformatf("sweep init_done c%0d", cycles), DW'(init_o[0]), '0);
            tick();
            cycles++;
        end
        $display("sweep done: req_ready rose in cycle %0d", cycles);
        check_eq("sweep length", DW'(cycles), DW'(17));
        check_eq("ready after sweep", DW'(ready_o), DW'(3'b111));
        check_eq("init_done after sweep", DW'(init_o), DW'(3'b111));
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        #2;
        // Test 1: reset, sweep timing, every word reads back as zero
        apply_reset();
        for (int a = 0; a < 16; a++) add_op(1'b0, 1'b1, AW'(a), '0, '0, 32'h0, 1'b0);
        run_ops();

        // Test 2: full write, partial byte write, no-op write, read back
        add_op(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 4'b1111, '0, 1'b0);
        add_op(1'b1, 1'b1, 4'd5, 32'h00001200, 4'b0010, '0, 1'b0);
        add_op(1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'b0000, '0, 1'b0);
        add_op(1'b0, 1'b1, 4'd5, '0, '0, 32'hDEAD12EF, 1'b0);
        run_ops();

        // Test 3: back-to-back reads are pipelined and returned in order
        add_op(1'b1, 1'b1, 4'd1, 32'h000000A1, 4'b1111, '0, 1'b0);
        add_op(1'b1, 1'b1, 4'd2, 32'h0000B200, 4'b1111, '0, 1'b0);
        add_op(1'b1, 1'b1, 4'd3, 32'h00C30000, 4'b1111, '0, 1'b0);
        add_op(1'b0, 1'b1, 4'd1, '0, '0, 32'h000000A1, 1'b0);
        add_op(1'b0, 1'b1, 4'd2, '0, '0, 32'h0000B200, 1'b0);
        add_op(1'b0, 1'b1, 4'd3, '0, '0, 32'h00C30000, 1'b0);
        run_ops();

        // Test 4: in-flight read sees old data, later read sees new, chip_select=0 is dropped
        add_op(1'b0, 1'b1, 4'd7, '0, '0, 32'h00000000, 1'b0);
        add_op(1'b1, 1'b1, 4'd7, 32'h00000011, 4'b1111, '0, 1'b0);
        add_op(1'b0, 1'b1, 4'd7, '0, '0, 32'h00000011, 1'b0);
        add_op(1'b1, 1'b0, 4'd7, 32'h00000022, 4'b1111, '0, 1'b0);
        add_op(1'b0, 1'b0, 4'd7, '0, '0, 32'h0, 1'b0);
        add_op(1'b0, 1'b1, 4'd7, '0, '0, 32'h00000011, 1'b0);
        run_ops();

        // Test 5: reset with reads in flight discards them and re-clears memory
        cs = 1'b1; req_v = 1'b1; we = 1'b0; addr = 4'd5;
        $display("op 0: read addr=5 before reset");
        tick();
        addr = 4'd3;
        $display("op 1: read addr=3 before reset");
        tick();
        drive_idle();
        apply_reset();
        add_op(1'b0, 1'b1, 4'd5, '0, '0, 32'h0, 1'b0);
        add_op(1'b0, 1'b1, 4'd3, '0, '0, 32'h0, 1'b0);
        run_ops();

`ifdef RAM_SYNC_PARITY_EN
        // Test 6: a corrupted stored bit raises parity_err; a clean word does not
        begin
            logic [8:0] t;
            add_op(1'b1, 1'b1, 4'd8, 32'hA5A5A5A5, 4'b1111, '0, 1'b0);
            add_op(1'b1, 1'b1, 4'd9, 32'h12345678, 4'b1111, '0, 1'b0);
            run_ops();
            t = g_dut[0].u_dut.g_lane[1].lane_mem[9]; t[0] = ~t[0];
            g_dut[0].u_dut.g_lane[1].lane_mem[9] = t;
            t = g_dut[1].u_dut.g_lane[1].lane_mem[9]; t[0] = ~t[0];
            g_dut[1].u_dut.g_lane[1].lane_mem[9] = t;
            t = g_dut[2].u_dut.g_lane[1].lane_mem[9]; t[0] = ~t[0];
            g_dut[2].u_dut.g_lane[1].lane_mem[9] = t;
            add_op(1'b0, 1'b1, 4'd9, '0, '0, 32'h12345778, 1'b1);
            add_op(1'b0, 1'b1, 4'd8, '0, '0, 32'hA5A5A5A5, 1'b0);
            run_ops();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
